// File: rtl/mar_ram.sv
// SAP-2 bus-side memory: memory address register plus 2**AW x DW RAM on the
// shared tri-state bus, with a program-load FSM that fills RAM before the CPU runs.
module mar_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clr,
  inout  wire  [DW-1:0] bus,
  input  logic          lm,
  input  logic          im,
  input  logic          em,
  input  logic          wm,
  input  logic          pl_start,
  input  logic [DW-1:0] pl_data,
  input  logic          pl_valid,
  input  logic          pl_last,
  output logic          pl_ready,
  output logic          pl_done,
  output logic          busy,
  output logic [AW-1:0] mar
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] PROG = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [2**AW];

  logic drive_en;
  logic run_wr;
  logic pl_wr;
  logic pl_end;

  // clr is folded in so the bus is released the instant reset asserts
  assign drive_en = clr && (state == RUN) && em && !lm;
  assign bus      = drive_en ? mem[mar] : {DW{1'bz}};

  assign run_wr   = clr && (state == RUN) && wm && !em;
  assign pl_wr    = clr && (state == PROG) && pl_valid;
  assign pl_end   = pl_wr && (pl_last || (ptr == {AW{1'b1}}));

  assign pl_ready = (state == PROG);
  assign busy     = (state == PROG);
  assign pl_done  = (state == FIN);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RUN;
      mar   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (lm)
            mar <= bus[AW-1:0];
          else if (im)
            mar <= mar + 1'b1;
          if (pl_start) begin
            state <= PROG;
            ptr   <= '0;
          end
        end
        PROG: begin
          if (pl_wr) begin
            ptr <= ptr + 1'b1;
            if (pl_end)
              state <= FIN;
          end
        end
        FIN: begin
          mar   <= '0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // RAM is never reset; a write in RUN uses the pre-edge mar
  always_ff @(posedge clk) begin
    if (run_wr)
      mem[mar] <= bus;
    else if (pl_wr)
      mem[ptr] <= pl_data;
  end

endmodule

// File: tb/tb_mar_ram.sv
// Directed bench for mar_ram: reset, program load, fetch path, write/readback
// precedence, MAR wrap, full-depth load and reset during a load.
module tb_mar_ram;

  logic       clk = 1'b0;
  logic       clr;
  wire  [7:0] bus;
  logic       lm, im, em, wm;
  logic       pl_start, pl_valid, pl_last;
  logic [7:0] pl_data;
  logic       pl_ready, pl_done, busy;
  logic [7:0] mar;

  logic       drv_en;
  logic [7:0] drv_val;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  assign bus = drv_en ? drv_val : 8'hzz;

  always #5 clk = ~clk;

  always @(posedge clk) if (pl_done === 1'b1) done_cnt <= done_cnt + 1;

  mar_ram #(.AW(8), .DW(8)) dut (
    .clk(clk), .clr(clr), .bus(bus),
    .lm(lm), .im(im), .em(em), .wm(wm),
    .pl_start(pl_start), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(pl_ready), .pl_done(pl_done), .busy(busy), .mar(mar)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [7:0] a);
    drv_en = 1'b1; drv_val = a; lm = 1'b1;
    tick();
    lm = 1'b0; drv_en = 1'b0;
  endtask

  task automatic read_at(input string tag, input logic [7:0] a, input logic [7:0] exp);
    load_mar(a);
    em = 1'b1;
    #1;
    check(tag, bus, exp);
    em = 1'b0;
  endtask

  initial begin
    clr = 1'b0; lm = 0; im = 0; em = 0; wm = 0;
    pl_start = 0; pl_valid = 0; pl_last = 0; pl_data = 8'h00;
    drv_en = 0; drv_val = 8'h00;

    // Reset then idle
    tick(); tick();
    check("rst_mar", mar, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_ready", {7'b0, pl_ready}, 8'h00);
    check("rst_done", {7'b0, pl_done}, 8'h00);
    clr = 1'b1;
    tick();
    check("idle_mar", mar, 8'h00);
    check("idle_busy", {7'b0, busy}, 8'h00);

    // Program load with a valid gap
    pl_start = 1'b1;
    tick();
    pl_start = 1'b0;
    check("prog_busy", {7'b0, busy}, 8'h01);
    check("prog_ready", {7'b0, pl_ready}, 8'h01);
    pl_valid = 1'b1; pl_data = 8'h0a;
    tick();
    pl_valid = 1'b0;
    tick();
    check("gap_ready", {7'b0, pl_ready}, 8'h01);
    pl_valid = 1'b1; pl_data = 8'h1b;
    tick();
    pl_data = 8'h2c; pl_last = 1'b1;
    tick();
    pl_valid = 1'b0; pl_last = 1'b0;
    check("fin_done", {7'b0, pl_done}, 8'h01);
    check("fin_ready", {7'b0, pl_ready}, 8'h00);
    check("fin_busy", {7'b0, busy}, 8'h00);
    tick();
    check("run_done", {7'b0, pl_done}, 8'h00);
    check("load_mar0", mar, 8'h00);
    check("done_once", 8'(done_cnt), 8'h01);

    // Fetch path
    read_at("ram0", 8'h00, 8'h0a);
    read_at("fetch1", 8'h01, 8'h1b);
    check("mar_lm", mar, 8'h01);
    im = 1'b1;
    tick();
    im = 1'b0;
    check("mar_inc", mar, 8'h02);
    em = 1'b1;
    #1;
    check("fetch2", bus, 8'h2c);
    em = 1'b0;

    // Write and readback
    load_mar(8'h40);
    drv_en = 1'b1; drv_val = 8'haa; wm = 1'b1;
    tick();
    wm = 1'b0; drv_en = 1'b0;
    em = 1'b1;
    #1;
    check("wr_aa", bus, 8'haa);
    // Deliberate contention so a non-suppressed write would store a corrupted byte
    wm = 1'b1; drv_en = 1'b1; drv_val = 8'h55;
    tick();
    wm = 1'b0; drv_en = 1'b0;
    #1;
    check("wm_em_keep", bus, 8'haa);
    // lm+em: only the external value may appear on the bus
    drv_en = 1'b1; drv_val = 8'h01; lm = 1'b1;
    #1;
    check("lm_em_bus", bus, 8'h01);
    tick();
    lm = 1'b0; em = 1'b0; drv_en = 1'b0;
    check("lm_em_mar", mar, 8'h01);
    // lm+wm: write lands at the pre-edge mar (0x01)
    drv_en = 1'b1; drv_val = 8'h30; lm = 1'b1; wm = 1'b1;
    tick();
    lm = 1'b0; wm = 1'b0; drv_en = 1'b0;
    check("lm_wm_mar", mar, 8'h30);
    read_at("lm_wm_ram", 8'h01, 8'h30);

    // MAR wrap
    load_mar(8'hff);
    check("mar_ff", mar, 8'hff);
    im = 1'b1;
    tick();
    im = 1'b0;
    check("mar_wrap", mar, 8'h00);

    // Full-depth load without pl_last; bus controls ignored in PROG
    pl_start = 1'b1;
    tick();
    pl_start = 1'b0;
    em = 1'b1; im = 1'b1; drv_en = 1'b1; drv_val = 8'h00;
    #1;
    check("prog_no_drive", bus, 8'h00);
    tick();
    em = 1'b0; im = 1'b0; drv_en = 1'b0;
    check("prog_no_inc", mar, 8'h00);
    for (int i = 0; i < 256; i++) begin
      pl_valid = 1'b1; pl_data = 8'(i + 8'h11);
      tick();
      if (i == 254) check("full_busy", {7'b0, busy}, 8'h01);
    end
    pl_valid = 1'b0;
    check("full_done", {7'b0, pl_done}, 8'h01);
    tick();
    check("full_done_cnt", 8'(done_cnt), 8'h02);
    read_at("full_ff", 8'hff, 8'h10);
    read_at("full_80", 8'h80, 8'h91);
    read_at("full_00", 8'h00, 8'h11);

    // Reset during a load
    pl_start = 1'b1;
    tick();
    pl_start = 1'b0;
    pl_valid = 1'b1; pl_data = 8'hc1;
    tick();
    pl_data = 8'hc2;
    tick();
    pl_valid = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    check("abort_busy", {7'b0, busy}, 8'h00);
    check("abort_ready", {7'b0, pl_ready}, 8'h00);
    tick();
    clr = 1'b1;
    tick();
    check("abort_no_done", 8'(done_cnt), 8'h02);
    pl_start = 1'b1;
    tick();
    pl_start = 1'b0;
    pl_valid = 1'b1; pl_data = 8'hd1; pl_last = 1'b1;
    tick();
    pl_valid = 1'b0; pl_last = 1'b0;
    tick();
    check("reload_done", 8'(done_cnt), 8'h03);
    read_at("reload_0", 8'h00, 8'hd1);
    read_at("keep_1", 8'h01, 8'hc2);
    read_at("keep_2", 8'h02, 8'h13);

    // Reset releases the bus immediately
    em = 1'b1;
    #1;
    check("pre_rst_drive", bus, 8'h13);
    clr = 1'b0; drv_en = 1'b1; drv_val = 8'h00;
    #1;
    check("rst_release", bus, 8'h00);
    check("rst_mar_async", mar, 8'h00);
    em = 1'b0; drv_en = 1'b0;
    tick();
    clr = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mar_ram.md
Name: mar_ram

Overview:
- Bus-side memory for the SAP-2 mini datapath: memory address register (MAR) plus 256x8 RAM on the shared 8-bit tri-state bus.
- Receiving end of the PC's bus transfer. The PC drives an address (ep), this block latches it (lm), and the block drives the addressed byte back onto the bus (em) or stores a bus byte (wm).
- Includes a program-load FSM that fills RAM from an external byte stream before the CPU runs.

Parameters:
- AW, 8, address width; MAR width; RAM depth = 2**AW.
- DW, 8, data width; must equal the bus width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset; asynchronous, active-low.
- bus  inout  DW  shared system bus; high-Z unless this block drives it.
- lm  input  1  load MAR from bus.
- im  input  1  increment MAR.
- em  input  1  drive RAM[MAR] onto bus.
- wm  input  1  write bus into RAM[MAR].
- pl_start  input  1  request program-load mode.
- pl_data  input  DW  program byte.
- pl_valid  input  1  pl_data valid.
- pl_last  input  1  qualifies the final byte.
- pl_ready  output  1  block accepts a byte this cycle.
- pl_done  output  1  one-cycle pulse at end of load.
- busy  output  1  high while in PROG state.
- mar  output  AW  current MAR value (debug/front panel).

Behaviour:
- Reset (clr=0, asynchronous):
  - mar=0, load pointer ptr=0, state=RUN.
  - pl_ready=0, pl_done=0, busy=0.
  - bus released to high-Z immediately.
  - RAM contents are not cleared.
- States: RUN, PROG, FIN.
- RUN:
  - Bus read: bus = RAM[mar] combinationally while em=1 and lm=0; otherwise high-Z. Zero-cycle latency, matching the SAP bus timing.
  - lm=1: mar <= bus at the edge. Takes priority over im.
  - im=1 (lm=0): mar <= mar+1, wrapping 255 -> 0.
  - wm=1 and em=0: RAM[mar] <= bus at the edge, using the pre-edge mar even if lm/im are also active.
  - wm=1 with em=1: write suppressed; bus still driven.
  - lm=1 with em=1: em suppressed (bus stays Z from this block); mar loads the external value.
  - pl_start=1: next state PROG, ptr <= 0. lm/im/wm in the same cycle still take effect.
- PROG:
  - busy=1, pl_ready=1. The bus is never driven; lm/im/em/wm are ignored.
  - On pl_valid & pl_ready: RAM[ptr] <= pl_data, ptr <= ptr+1.
  - If pl_last=1, or ptr==2**AW-1 at the accepted byte, next state is FIN.
  - pl_valid=0: no write, ptr holds.
  - pl_start is ignored in PROG.
- FIN (one cycle):
  - pl_done=1, pl_ready=0, busy=0, mar <= 0, then RUN.
  - Control inputs are ignored during FIN.
- Reset mid-PROG: returns to RUN with ptr=0. Bytes already written are retained. pl_done is not issued.
- ptr and mar are independent registers. The load never modifies mar except the FIN clear.

Test Plan:
- Reset then idle: clr=0 for 2 cycles, release, all controls low -> mar=0, bus=Z, busy=0, pl_ready=0.
- Program load: pulse pl_start, stream 8'h0a, 8'h1b, 8'h2c (pl_last on 2c), with a pl_valid gap between bytes 1 and 2 -> pl_ready high for the PROG cycles only; RAM[0..2]=0a,1b,2c; pl_done pulses exactly once; mar=0 afterwards.
- Fetch path: external driver puts 8'h01 on bus with lm=1, then em=1 -> bus reads 8'h1b. Then im=1 for one cycle, em=1 -> bus reads 8'h2c.
- Write/readback and precedence:
  - lm with bus=8'h40, then wm with bus=8'haa -> em reads 8'haa.
  - wm+em together at mar=8'h40 -> RAM unchanged.
  - lm+em together -> bus carries only the external value.
- Wrap: lm 8'hff then im -> mar=8'h00. Full 256-byte load without pl_last -> FIN after byte 255; RAM[255] correct.
- Reset mid-PROG: clr=0 after 2 accepted bytes -> busy=0 asynchronously, no pl_done. A new pl_start reloads from address 0.
